// File: rtl/cond_flag_unit.sv
// Condition-evaluation stage: holds the NZCV flags, gates the write strobes of
// each executing instruction, and counts instructions squashed by their condition.
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Cond,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic [3:0]       ALUFlags,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] squash_count
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex;
    logic accept;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];

    assign in_ready = ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // reserved encoding squashes
        endcase
    end

    // Output entry: flush wins over accept and drain; a stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
            CondEx    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
            CondEx    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            PCSrc     <= PCS & cond_ex;
            RegWrite  <= RegW & cond_ex & ~NoWrite;
            MemWrite  <= MemW & cond_ex;
            CondEx    <= cond_ex;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
            CondEx    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Flags <= 4'b0000;
        end else if (accept && cond_ex) begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_count <= '0;
        end else if (accept && !cond_ex && (squash_count != {CNT_W{1'b1}})) begin
            squash_count <= squash_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios with literal expectations, then
// randomized traffic checked each cycle against a behavioural model.
module tb_cond_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, RegW, MemW, NoWrite;

    logic        in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]  Flags;
    logic [15:0] squash_count;
    logic        in_ready_s, out_valid_s, PCSrc_s, RegWrite_s, MemWrite_s, CondEx_s;
    logic [3:0]  Flags_s;
    logic [1:0]  squash_count_s;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_valid, m_pcsrc, m_regw, m_memw, m_ce;
    logic [3:0]  m_flags;
    int          m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    cond_flag_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Cond(Cond), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .ALUFlags(ALUFlags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .squash_count(squash_count)
    );

    cond_flag_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .Cond(Cond), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .ALUFlags(ALUFlags), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready), .PCSrc(PCSrc_s),
        .RegWrite(RegWrite_s), .MemWrite(MemWrite_s), .CondEx(CondEx_s),
        .Flags(Flags_s), .squash_count(squash_count_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each condition mnemonic.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pcsrc = 0; m_regw = 0; m_memw = 0; m_ce = 0;
        m_flags = 4'h0; m_cnt16 = 0; m_cnt2 = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("PCSrc", PCSrc, m_pcsrc);
        chk("RegWrite", RegWrite, m_regw);
        chk("MemWrite", MemWrite, m_memw);
        chk("CondEx", CondEx, m_ce);
        chk("Flags", Flags, m_flags);
        chk("squash_count", squash_count, m_cnt16);
        chk("small_out_valid", out_valid_s, m_valid);
        chk("small_strobes", {PCSrc_s, RegWrite_s, MemWrite_s, CondEx_s},
            {m_pcsrc, m_regw, m_memw, m_ce});
        chk("small_Flags", Flags_s, m_flags);
        chk("small_squash_count", squash_count_s, m_cnt2);
    endtask

    // Entered at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic rdy, acc, ce;
        #1;
        rdy = !flush && (!m_valid || out_ready);
        chk("in_ready", in_ready, rdy);
        chk("small_in_ready", in_ready_s, rdy);
        acc = in_valid && rdy;
        ce  = cond_holds(Cond, m_flags);
        @(posedge clk);
        if (flush || (!acc && out_ready)) begin
            m_valid = 0; m_pcsrc = 0; m_regw = 0; m_memw = 0; m_ce = 0;
        end else if (acc) begin
            m_valid = 1;
            m_ce    = ce;
            m_pcsrc = PCS && ce;
            m_regw  = RegW && ce && !NoWrite;
            m_memw  = MemW && ce;
            if (ce) begin
                if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
            end else begin
                m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
                m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic iv, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] alu, input logic pcs, input logic rw,
                         input logic mw, input logic nw, input logic ordy, input logic fl);
        in_valid = iv; Cond = c; FlagW = fw; ALUFlags = alu;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; out_ready = ordy; flush = fl;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(1, 4'hE, 2'b11, f, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("set_flags", Flags, f);
    endtask

    task automatic eval(input logic [3:0] c, input logic exp_ce);
        drive(1, c, 2'b00, 4'h0, 0, 0, 0, 0, 1, 0);
        cycle();
        chk($sformatf("cond_%0h", c), CondEx, exp_ce);
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        check_outputs();

        // flag set, then conditional execution on it
        drive(1, 4'hE, 2'b11, 4'b0100, 0, 1, 0, 1, 1, 0);
        cycle();
        chk("t1_flags", Flags, 4'b0100);
        chk("t1_regwrite", RegWrite, 0);
        drive(1, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 1, 0);
        cycle();
        chk("t2_condex", CondEx, 1);
        chk("t2_regwrite", RegWrite, 1);
        drive(1, 4'h1, 2'b00, 4'h0, 0, 0, 1, 0, 1, 0);
        cycle();
        chk("t3_condex", CondEx, 0);
        chk("t3_memwrite", MemWrite, 0);
        chk("t3_squash", squash_count, 1);

        // partial update and squashed flag-setter
        set_flags(4'hF);
        drive(1, 4'hE, 2'b10, 4'h0, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("partial_flags", Flags, 4'b0011);
        set_flags(4'h0);
        drive(1, 4'h0, 2'b11, 4'hF, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("squashed_setter_flags", Flags, 4'b0000);
        chk("squashed_setter_cnt", squash_count, 2);

        // signed and unsigned compares
        set_flags(4'b1001);
        eval(4'hA, 1); eval(4'hB, 0); eval(4'hC, 1); eval(4'hD, 0);
        set_flags(4'b1000);
        eval(4'hA, 0); eval(4'hB, 1); eval(4'hD, 1);
        set_flags(4'b0010);
        eval(4'h8, 1);
        set_flags(4'b0110);
        eval(4'h8, 0); eval(4'h9, 1); eval(4'hF, 0);

        // stall, simultaneous replace, drain
        drive(1, 4'hE, 2'b00, 4'h0, 1, 1, 0, 0, 1, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hE, 2'b11, 4'h9, 0, 0, 1, 0, 0, 0);
            cycle();
            chk("stall_in_ready", in_ready, 0);
            chk("stall_pcsrc", PCSrc, 1);
        end
        drive(1, 4'hE, 2'b00, 4'h0, 0, 0, 1, 0, 1, 0);
        cycle();
        chk("replace_valid", out_valid, 1);
        chk("replace_memwrite", MemWrite, 1);
        chk("replace_pcsrc", PCSrc, 0);
        drive(0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("drain_valid", out_valid, 0);

        // flush dominates accept
        drive(1, 4'hE, 2'b00, 4'h0, 1, 0, 0, 0, 1, 0);
        cycle();
        drive(1, 4'hE, 2'b11, 4'hF, 1, 1, 1, 0, 1, 1);
        cycle();
        chk("flush_valid", out_valid, 0);
        chk("flush_flags", Flags, 4'b0110);

        // asynchronous reset in the middle of a stall
        drive(1, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("prereset_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_strobes", {PCSrc, RegWrite, MemWrite, CondEx}, 4'b0000);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_squash", squash_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'h0, 2'b11, 4'hF, 0, 0, 0, 0, 1, 0);
            cycle();
        end
        chk("sat_small", squash_count_s, 3);
        chk("sat_wide", squash_count, 5);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
                  4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
